// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller:
// FSM states, opcodes, ALUOp/ALUControl codes and funct3 constants.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [3:0] ALUC_ADD  = 4'b0000;
  localparam logic [3:0] ALUC_SUB  = 4'b0001;
  localparam logic [3:0] ALUC_AND  = 4'b0010;
  localparam logic [3:0] ALUC_OR   = 4'b0011;
  localparam logic [3:0] ALUC_XOR  = 4'b0100;
  localparam logic [3:0] ALUC_SLT  = 4'b0101;
  localparam logic [3:0] ALUC_SLL  = 4'b0110;
  localparam logic [3:0] ALUC_SRL  = 4'b0111;
  localparam logic [3:0] ALUC_SRA  = 4'b1000;
  localparam logic [3:0] ALUC_SLTU = 4'b1001;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder_ext.sv
// ALU control decoder; ALUCTRL_W = 3 gives the base op set, 4 adds
// xor/sll/srl/sra/sltu (unsupported funct3 falls back to add).
module alu_decoder_ext
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3
) (
  input  aluop_e               alu_op_i,
  input  logic                 op5_i,
  input  logic [2:0]           funct3_i,
  input  logic                 funct7b5_i,
  output logic [ALUCTRL_W-1:0] alu_control_o
);

  localparam bit EXT = (ALUCTRL_W >= 4);

  always_comb begin
    alu_control_o = ALUCTRL_W'(ALUC_ADD);
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALUCTRL_W'(ALUC_SUB);
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type may subtract; funct7b5 in I-type is immediate data.
          F3_ADDSUB: alu_control_o = (op5_i & funct7b5_i) ? ALUCTRL_W'(ALUC_SUB)
                                                           : ALUCTRL_W'(ALUC_ADD);
          F3_SLT:    alu_control_o = ALUCTRL_W'(ALUC_SLT);
          F3_OR:     alu_control_o = ALUCTRL_W'(ALUC_OR);
          F3_AND:    alu_control_o = ALUCTRL_W'(ALUC_AND);
          F3_XOR:    if (EXT) alu_control_o = ALUCTRL_W'(ALUC_XOR);
          F3_SLL:    if (EXT) alu_control_o = ALUCTRL_W'(ALUC_SLL);
          F3_SR:     if (EXT) alu_control_o = funct7b5_i ? ALUCTRL_W'(ALUC_SRA)
                                                         : ALUCTRL_W'(ALUC_SRL);
          F3_SLTU:   if (EXT) alu_control_o = ALUCTRL_W'(ALUC_SLTU);
          default:   alu_control_o = ALUCTRL_W'(ALUC_ADD);
        endcase
      end
      default: alu_control_o = ALUCTRL_W'(ALUC_ADD);
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle RISC-V datapath with memory-ready waits.
// Optional ILLEGAL_TRAP_EN: unrecognised opcodes park in TRAP and raise Illegal until reset.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W   = 3,
  parameter bit          FULL_BRANCH = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 Neg,
  input  logic                 Carry,
  input  logic                 Ovf,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           State
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                 Illegal
`endif
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_e BAD_OP_NEXT = S_TRAP;
`else
  localparam state_e BAD_OP_NEXT = S_FETCH;
`endif

  state_e state_q, state_d;
  aluop_e alu_op;
  logic   pc_update;
  logic   branch;
  logic   taken;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = BAD_OP_NEXT;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_ALUWB, S_MEMWB, S_BRANCH:    state_d = S_FETCH;
      // TRAP holds when enabled; otherwise unreachable and recovers to FETCH.
      S_TRAP:     state_d = BAD_OP_NEXT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = '0;
    ALUSrcA   = '0;
    ALUSrcB   = '0;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        pc_update = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Carry is the no-borrow flag of the subtract, so unsigned less-than is !Carry.
  always_comb begin
    taken = 1'b0;
    if (FULL_BRANCH) begin
      case (funct3)
        F3_BEQ:  taken = Zero;
        F3_BNE:  taken = ~Zero;
        F3_BLT:  taken = Neg ^ Ovf;
        F3_BGE:  taken = ~(Neg ^ Ovf);
        F3_BLTU: taken = ~Carry;
        F3_BGEU: taken = Carry;
        default: taken = 1'b0;
      endcase
    end else begin
      taken = (funct3 == F3_BEQ) & Zero;
    end
  end

  assign PCWrite = pc_update | (branch & taken);

  always_comb begin
    case (op)
      OP_ITYPE, OP_LOAD: ImmSrc = 2'b00;
      OP_STORE:          ImmSrc = 2'b01;
      OP_BRANCH:         ImmSrc = 2'b10;
      OP_JAL:            ImmSrc = 2'b11;
      default:           ImmSrc = 2'b00;
    endcase
  end

  alu_decoder_ext #(
    .ALUCTRL_W(ALUCTRL_W)
  ) u_alu_dec (
    .alu_op_i     (alu_op),
    .op5_i        (op[5]),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .alu_control_o(ALUControl)
  );

  assign State = state_q;

`ifdef ILLEGAL_TRAP_EN
  assign Illegal = (state_q == S_TRAP);
`endif

endmodule
